// File: rtl/nn_pixel_loader_if.sv
// rtl/nn_pixel_loader_if.sv - pixel stream, core handshake and result bundle for nn_pixel_loader
interface nn_pixel_loader_if #(
  parameter int CNT_W = 32
);
  // upstream packed-pixel word stream and control
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             soft_clr;

  // byte-wide pixel write port into the core
  logic             pix_we;
  logic [9:0]       pix_addr;
  logic [7:0]       pix_data;

  // core level start/done handshake
  logic             core_start;
  logic             core_done;
  logic [3:0]       core_pred;

  // software readback
  logic             busy;
  logic             result_valid;
  logic [3:0]       result;
  logic [CNT_W-1:0] infer_cycles;
  logic [15:0]      frame_cnt;

  // loader side
  modport slave (
    input  in_valid, in_data, soft_clr, core_done, core_pred,
    output in_ready, pix_we, pix_addr, pix_data, core_start,
           busy, result_valid, result, infer_cycles, frame_cnt
  );

  // register path / core side
  modport master (
    output in_valid, in_data, soft_clr, core_done, core_pred,
    input  in_ready, pix_we, pix_addr, pix_data, core_start,
           busy, result_valid, result, infer_cycles, frame_cnt
  );
endinterface

// File: rtl/nn_pixel_loader.sv
// rtl/nn_pixel_loader.sv - unpacks 32-bit pixel words into nn_core and sequences one inference per frame
module nn_pixel_loader #(
  parameter int N_IN  = 784,   // multiple of 4, at most 1024
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  nn_pixel_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_UNPACK,
    S_RUN,
    S_RELEASE,
    S_ABORT
  } state_t;

  localparam logic [9:0] LAST_ADDR = 10'(N_IN - 1);

  state_t           r_state;
  logic [9:0]       r_idx;          // next pixel address to write
  logic [31:0]      r_buf;          // captured word being unpacked
  logic [1:0]       r_k;            // byte currently on the pixel port
  logic             r_done_seen;    // ABORT: core done has been observed high

  logic             r_in_ready;
  logic             r_busy;
  logic             r_pix_we;
  logic [9:0]       r_pix_addr;
  logic [7:0]       r_pix_data;
  logic             r_core_start;
  logic             r_result_valid;
  logic [3:0]       r_result;
  logic [CNT_W-1:0] r_infer_cycles;
  logic [15:0]      r_frame_cnt;

  logic [1:0]       w_next_k;
  logic [7:0]       w_next_byte;
  logic [9:0]       w_idx_inc;

  assign w_next_k    = r_k + 2'd1;
  assign w_next_byte = r_buf[{w_next_k, 3'b000} +: 8];
  // wrap keeps the index inside the frame even on the final byte
  assign w_idx_inc   = (r_idx == LAST_ADDR) ? 10'd0 : r_idx + 10'd1;

  // in_ready and busy are registered alongside the state so every output is 0 in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_LOAD;
      r_idx          <= '0;
      r_buf          <= '0;
      r_k            <= '0;
      r_done_seen    <= 1'b0;
      r_in_ready     <= 1'b0;
      r_busy         <= 1'b0;
      r_pix_we       <= 1'b0;
      r_pix_addr     <= '0;
      r_pix_data     <= '0;
      r_core_start   <= 1'b0;
      r_result_valid <= 1'b0;
      r_result       <= '0;
      r_infer_cycles <= '0;
      r_frame_cnt    <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
          if (bus.soft_clr) begin
            r_idx <= '0;
          end else if (r_in_ready && bus.in_valid) begin
            // byte 0 goes out on the very next cycle
            r_buf          <= bus.in_data;
            r_result_valid <= 1'b0;
            r_pix_we       <= 1'b1;
            r_pix_addr     <= r_idx;
            r_pix_data     <= bus.in_data[7:0];
            r_idx          <= w_idx_inc;
            r_k            <= 2'd0;
            r_in_ready     <= 1'b0;
            r_busy         <= 1'b1;
            r_state        <= S_UNPACK;
          end
        end

        S_UNPACK: begin
          if (bus.soft_clr) begin
            // drop the partial frame; the pending byte is never written
            r_pix_we   <= 1'b0;
            r_idx      <= '0;
            r_k        <= 2'd0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_LOAD;
          end else if (r_k == 2'd3) begin
            r_pix_we <= 1'b0;
            r_k      <= 2'd0;
            if (r_pix_addr == LAST_ADDR) begin
              r_idx          <= '0;
              r_infer_cycles <= '0;
              r_core_start   <= 1'b1;
              r_state        <= S_RUN;
            end else begin
              r_in_ready <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= S_LOAD;
            end
          end else begin
            r_pix_addr <= r_idx;
            r_pix_data <= w_next_byte;
            r_idx      <= w_idx_inc;
            r_k        <= w_next_k;
          end
        end

        S_RUN: begin
          if (bus.soft_clr) begin
            // core cannot be stopped; wait it out before touching its pixel buffer
            r_core_start <= 1'b0;
            r_done_seen  <= 1'b0;
            r_state      <= S_ABORT;
          end else if (bus.core_done) begin
            r_core_start   <= 1'b0;
            r_result       <= bus.core_pred;
            r_result_valid <= 1'b1;
            r_frame_cnt    <= r_frame_cnt + 16'd1;
            r_state        <= S_RELEASE;
          end else if (r_infer_cycles != '1) begin
            r_infer_cycles <= r_infer_cycles + CNT_W'(1);
          end
        end

        S_RELEASE: begin
          // start stays low until done drops, giving the core a clean next rising edge
          if (!bus.core_done) begin
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_LOAD;
          end
        end

        S_ABORT: begin
          if (!r_done_seen) begin
            if (bus.core_done) r_done_seen <= 1'b1;
          end else if (!bus.core_done) begin
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_LOAD;
          end
        end

        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.busy         = r_busy;
  assign bus.pix_we       = r_pix_we;
  assign bus.pix_addr     = r_pix_addr;
  assign bus.pix_data     = r_pix_data;
  assign bus.core_start   = r_core_start;
  assign bus.result_valid = r_result_valid;
  assign bus.result       = r_result;
  assign bus.infer_cycles = r_infer_cycles;
  assign bus.frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_nn_pixel_loader.sv
// tb/tb_nn_pixel_loader.sv - directed self-checking bench for nn_pixel_loader with a stub core
module tb_nn_pixel_loader;
  localparam int N_IN  = 784;
  localparam int CNT_W = 32;
  localparam int DELAY = 50;
  localparam int WORDS = N_IN / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  nn_pixel_loader_if #(.CNT_W(CNT_W)) bus ();

  nn_pixel_loader #(.N_IN(N_IN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // stub core: run starts on start rise, done high DELAY cycles later, held until start drops
  logic [3:0] stub_pred    = 4'd0;
  logic       stub_run     = 1'b0;
  logic       stub_start_d = 1'b0;
  logic       stub_done    = 1'b0;
  int         stub_cnt     = 0;
  always @(posedge clk) begin
    stub_start_d <= bus.core_start;
    if (stub_run) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt == DELAY - 1) begin
        stub_done <= 1'b1;
        stub_run  <= 1'b0;
      end
    end else if (bus.core_start && !stub_start_d && !stub_done) begin
      stub_run <= 1'b1;
      stub_cnt <= 1;
    end
    if (stub_done && !bus.core_start) stub_done <= 1'b0;
  end
  assign bus.core_done = stub_done;
  assign bus.core_pred = stub_pred;

  // write log and start-gap tracker, sampled just after each rising edge
  logic [9:0] wr_addr[$];
  logic [7:0] wr_data[$];
  int         start_low_len = 0;
  int         last_gap = -1;
  logic       prev_start = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (bus.pix_we) begin
      wr_addr.push_back(bus.pix_addr);
      wr_data.push_back(bus.pix_data);
    end
    if (bus.core_start && !prev_start) last_gap = start_low_len;
    start_low_len = bus.core_start ? 0 : start_low_len + 1;
    prev_start = bus.core_start;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word_of(input int w);
    return {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
  endfunction

  // offer one word from a falling edge; returns on the falling edge after acceptance
  task automatic send_one(input logic [31:0] d, output bit timeout);
    int n;
    n = 0;
    timeout = 1'b0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) timeout = 1'b1;
    else @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_words(input int first, input int last, output bit timeout);
    bit t;
    timeout = 1'b0;
    for (int w = first; w <= last; w++) begin
      send_one(word_of(w), t);
      if (t) begin
        timeout = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (!bus.result_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_load();
    int n;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.busy, bus.pix_we, bus.pix_addr, bus.pix_data, bus.core_start,
         bus.result_valid, bus.result, bus.infer_cycles, bus.frame_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got nonzero outputs ready=%b busy=%b we=%b start=%b fc=%0d, expected all 0",
               bus.in_ready, bus.busy, bus.pix_we, bus.core_start, bus.frame_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_load: ready=%b busy=%b expected 1 0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_full_frame();
    bit to;
    int bad;
    int first_bad;
    wr_addr.delete();
    wr_data.delete();
    stub_pred = 4'd7;
    send_words(0, WORDS - 1, to);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL full_stream: got timeout %b expected 0", to); end
    wait_result();
    n_checks++;
    if (bus.result_valid !== 1'b1) begin n_fail++; $display("FAIL full_result_valid: got %b expected 1", bus.result_valid); end
    n_checks++;
    if (bus.core_start !== 1'b0) begin n_fail++; $display("FAIL full_start_drop: got %b expected 0", bus.core_start); end
    n_checks++;
    if (bus.result !== 4'd7) begin n_fail++; $display("FAIL full_result: got %0d expected 7", bus.result); end
    n_checks++;
    if (bus.infer_cycles !== 32'd50) begin n_fail++; $display("FAIL full_infer_cycles: got %0d expected 50", bus.infer_cycles); end
    n_checks++;
    if (bus.frame_cnt !== 16'd1) begin n_fail++; $display("FAIL full_frame_cnt: got %0d expected 1", bus.frame_cnt); end
    n_checks++;
    if (wr_addr.size() !== N_IN) begin n_fail++; $display("FAIL full_write_count: got %0d expected %0d", wr_addr.size(), N_IN); end
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < wr_addr.size() && i < N_IN; i++) begin
      if (wr_addr[i] !== 10'(i) || wr_data[i] !== 8'(i)) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL full_write_content: got %0d bad writes (first at %0d) expected 0", bad, first_bad); end
    wait_load();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_return_load: got ready %b expected 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    bit to;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    stub_pred = 4'd3;
    send_words(0, WORDS - 1, to);
    wait_result();
    n_checks++;
    if (bus.result !== 4'd3) begin n_fail++; $display("FAIL b2b_result1: got %0d expected 3", bus.result); end
    wait_load();
    n_checks++;
    if (bus.result_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_held: got %b expected 1", bus.result_valid); end
    stub_pred = 4'd9;
    send_one(word_of(0), to);
    n_checks++;
    if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_drop: got %b expected 0", bus.result_valid); end
    send_words(1, WORDS - 1, to);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_stream: got timeout %b expected 0", to); end
    wait_result();
    n_checks++;
    if (bus.result !== 4'd9 || bus.result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_result2: got %0d valid %b expected 9 valid 1", bus.result, bus.result_valid);
    end
    n_checks++;
    if (bus.frame_cnt !== 16'd2) begin n_fail++; $display("FAIL b2b_frame_cnt: got %0d expected 2", bus.frame_cnt); end
    n_checks++;
    if (last_gap < 1) begin n_fail++; $display("FAIL b2b_start_gap: got %0d low cycles expected >=1", last_gap); end
    wait_load();
  endtask

  task automatic test_backpressure();
    int prev_c;
    int pulses;
    int bad;
    logic rdy;
    wr_addr.delete();
    wr_data.delete();
    prev_c = -1;
    pulses = 0;
    bus.in_data  = word_of(0);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      rdy = bus.in_ready;
      @(negedge clk);
      if (rdy) begin
        if (prev_c >= 0) begin
          n_checks++;
          if (c - prev_c !== 5) begin n_fail++; $display("FAIL bp_ready_spacing: got %0d expected 5", c - prev_c); end
        end
        prev_c = c;
        pulses++;
        bus.in_data = word_of(pulses);
      end
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (pulses !== 12) begin n_fail++; $display("FAIL bp_ready_pulses: got %0d expected 12", pulses); end
    repeat (6) @(negedge clk);
    n_checks++;
    if (wr_addr.size() !== 48) begin n_fail++; $display("FAIL bp_write_count: got %0d expected 48", wr_addr.size()); end
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] !== 10'(i) || wr_data[i] !== 8'(i)) bad++;
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL bp_addr_sequence: got %0d bad writes expected 0", bad); end
    // discard the partial frame from LOAD
    bus.soft_clr = 1'b1;
    @(negedge clk);
    bus.soft_clr = 1'b0;
  endtask

  task automatic test_soft_clr_load();
    bit to;
    int bad;
    wr_addr.delete();
    wr_data.delete();
    send_words(0, 9, to);
    send_one(word_of(10), to);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.pix_we !== 1'b1 || bus.pix_addr !== 10'd42) begin
      n_fail++;
      $display("FAIL sc_load_byte2: got we %b addr %0d expected 1 42", bus.pix_we, bus.pix_addr);
    end
    bus.soft_clr = 1'b1;
    @(negedge clk);
    bus.soft_clr = 1'b0;
    n_checks++;
    if (bus.pix_we !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL sc_load_abort: got we %b ready %b expected 0 1", bus.pix_we, bus.in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (wr_addr.size() !== 43) begin n_fail++; $display("FAIL sc_load_partial_count: got %0d expected 43", wr_addr.size()); end
    wr_addr.delete();
    wr_data.delete();
    stub_pred = 4'd5;
    send_words(0, WORDS - 1, to);
    wait_result();
    n_checks++;
    if (wr_addr.size() !== N_IN) begin n_fail++; $display("FAIL sc_load_write_count: got %0d expected %0d", wr_addr.size(), N_IN); end
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] !== 10'(i) || wr_data[i] !== 8'(i)) bad++;
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL sc_load_restart_addr: got %0d bad writes expected 0", bad); end
    n_checks++;
    if (bus.result !== 4'd5 || bus.frame_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL sc_load_inference: got result %0d fc %0d expected 5 3", bus.result, bus.frame_cnt);
    end
    wait_load();
  endtask

  task automatic test_soft_clr_run();
    bit to;
    int n;
    stub_pred = 4'd2;
    send_words(0, WORDS - 1, to);
    n = 0;
    while (!bus.core_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (bus.core_start !== 1'b1) begin n_fail++; $display("FAIL sc_run_start: got %b expected 1", bus.core_start); end
    repeat (10) @(negedge clk);
    bus.soft_clr = 1'b1;
    @(negedge clk);
    bus.soft_clr = 1'b0;
    n_checks++;
    if (bus.core_start !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sc_run_start_drop: got start %b busy %b expected 0 1", bus.core_start, bus.busy);
    end
    wr_addr.delete();
    wr_data.delete();
    n = 0;
    while (!bus.core_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (bus.core_done !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL sc_run_wait_done: got done %b ready %b expected 1 0", bus.core_done, bus.in_ready);
    end
    n = 0;
    while (bus.core_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL sc_run_hold: got ready %b expected 0", bus.in_ready); end
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sc_run_return_load: got ready %b busy %b expected 1 0", bus.in_ready, bus.busy);
    end
    n_checks++;
    if (wr_addr.size() !== 0) begin n_fail++; $display("FAIL sc_run_no_writes: got %0d writes expected 0", wr_addr.size()); end
    n_checks++;
    if (bus.result_valid !== 1'b0 || bus.frame_cnt !== 16'd3 || bus.result !== 4'd5) begin
      n_fail++;
      $display("FAIL sc_run_discard: got valid %b fc %0d result %0d expected 0 3 5",
               bus.result_valid, bus.frame_cnt, bus.result);
    end
  endtask

  task automatic test_async_reset();
    bit to;
    send_one(word_of(0), to);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.busy, bus.pix_we, bus.pix_addr, bus.pix_data, bus.core_start,
         bus.result_valid, bus.result, bus.infer_cycles, bus.frame_cnt} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got we=%b addr=%0d busy=%b fc=%0d expected all 0",
               bus.pix_we, bus.pix_addr, bus.busy, bus.frame_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    send_one(32'h11223344, to);
    repeat (5) @(negedge clk);
    n_checks++;
    if (wr_addr.size() !== 4) begin
      n_fail++;
      $display("FAIL async_next_count: got %0d expected 4", wr_addr.size());
    end else begin
      n_checks++;
      if ({wr_addr[0], wr_addr[1], wr_addr[2], wr_addr[3]} !== {10'd0, 10'd1, 10'd2, 10'd3} ||
          {wr_data[0], wr_data[1], wr_data[2], wr_data[3]} !== 32'h44332211) begin
        n_fail++;
        $display("FAIL async_next_word: got addr0 %0d data %h%h%h%h expected 0 44332211",
                 wr_addr[0], wr_data[0], wr_data[1], wr_data[2], wr_data[3]);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.soft_clr = 1'b0;
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_backpressure();
    test_soft_clr_load();
    test_soft_clr_run();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
